// File: rtl/alu_serial_nbit.sv
// Bit-serial WIDTH-bit ALU: one bit per clock, LSB first, through a single
// one-bit slice with a registered carry and a start/busy/done handshake.
module alu_serial_nbit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             illegal
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr, res_next;
  logic [3:0]       op_q;
  logic             c_q;
  logic [CW-1:0]    cnt_q;
  logic             last_bit, accept;
  logic             r_bit, c_next;
  logic [WIDTH-1:0] b_load;
  logic             cin_load;
  logic             is_arith_q, is_rsvd_q;

  assign is_arith_q = op_q[3] & ~op_q[2];
  assign is_rsvd_q  = op_q[3] & op_q[2];

  // The B shift register holds B' for arithmetic ops, so the slice only sees
  // a plain full adder; logic ops keep the raw B.
  always_comb begin
    b_load   = b;
    cin_load = 1'b0;
    if (op[3:2] == 2'b10) begin
      case (op[1:0])
        2'b01:   begin b_load = ~b;           cin_load = 1'b1; end
        2'b10:   begin b_load = '0;           cin_load = 1'b1; end
        2'b11:   begin b_load = {WIDTH{1'b1}}; cin_load = 1'b0; end
        default: begin b_load = b;            cin_load = 1'b0; end
      endcase
    end
  end

  // One-bit function slice.
  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    r_bit  = 1'b0;
    c_next = 1'b0;
    if (!op_q[3]) begin
      case (op_q[2:0])
        3'b000, 3'b100: r_bit = a_sr[0];
        3'b001, 3'b101: r_bit = ~a_sr[0];
        3'b010:         r_bit = a_sr[0] ^ b_sr[0];
        3'b011:         r_bit = ~(a_sr[0] ^ b_sr[0]);
        3'b110:         r_bit = a_sr[0] | b_sr[0];
        default:        r_bit = ~a_sr[0] | b_sr[0];
      endcase
    end else if (!op_q[2]) begin
      r_bit  = a_sr[0] ^ b_sr[0] ^ c_q;
      c_next = (a_sr[0] & b_sr[0]) | (a_sr[0] & c_q) | (b_sr[0] & c_q);
    end
  end

  assign res_next = {r_bit, res_sr[WIDTH-1:1]};

  // NOTE: state and datapath registers use non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // A start seen on the last-bit edge is accepted there, so back-to-back
  // operations run with no idle cycle between them.
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    last_bit = 1'b0;
    busy     = (state_q == RUN);
    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (cnt_q == LAST_BIT) begin
          last_bit = 1'b1;
          accept   = start;
          state_d  = start ? RUN : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr    <= '0;
      b_sr    <= '0;
      res_sr  <= '0;
      op_q    <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      done    <= 1'b0;
      result  <= '0;
      carry   <= 1'b0;
      zero    <= 1'b0;
      illegal <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state_q == RUN) begin
        a_sr   <= a_sr >> 1;
        b_sr   <= b_sr >> 1;
        res_sr <= res_next;
        c_q    <= c_next;
        cnt_q  <= cnt_q + 1'b1;
      end
      if (last_bit) begin
        result  <= res_next;
        carry   <= is_arith_q & c_next;
        zero    <= (res_next == '0);
        illegal <= is_rsvd_q;
        done    <= 1'b1;
      end
      // NOTE: a load here overrides the shift above; the later assignment wins.
      if (accept) begin
        a_sr   <= a;
        b_sr   <= b_load;
        op_q   <= op;
        c_q    <= cin_load;
        cnt_q  <= '0;
        res_sr <= '0;
      end
    end
  end

endmodule

// File: tb/tb_alu_serial_nbit.sv
// Directed bench for alu_serial_nbit: WIDTH=8 and WIDTH=16 instances,
// hand-computed expectations for arithmetic, logic, handshake and reset.
module tb_alu_serial_nbit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start8 = 1'b0, start16 = 1'b0;
  logic [3:0]  op8 = '0, op16 = '0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy8, done8, carry8, zero8, illegal8;
  logic [7:0]  result8;
  logic        busy16, done16, carry16, zero16, illegal16;
  logic [15:0] result16;

  int total = 0;
  int bad   = 0;
  int lat;
  int done_seen;

  always #5 clk = ~clk;

  alu_serial_nbit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .result(result8), .carry(carry8),
    .zero(zero8), .illegal(illegal8)
  );

  alu_serial_nbit #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .op(op16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .result(result16), .carry(carry16),
    .zero(zero16), .illegal(illegal16)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Start one WIDTH=8 op, then count edges until done (bounded).
  task automatic run8(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                      output int n);
    @(negedge clk);
    op8 = o; a8 = x; b8 = y; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    op8 = 4'b1111; a8 = 8'h00; b8 = 8'h00;
    n = 0;
    while (n < 40) begin
      @(posedge clk); #1;
      n++;
      if (done8) break;
    end
  endtask

  task automatic wait_done8(output int n);
    n = 0;
    while (n < 40) begin
      @(posedge clk); #1;
      n++;
      if (done8) break;
    end
  endtask

  initial begin
    #12;
    check("rst_busy", busy8, 0);
    check("rst_done", done8, 0);
    check("rst_result", result8, 0);
    check("rst_flags", {carry8, zero8, illegal8}, 0);
    @(negedge clk);
    rst = 1'b0;

    run8(4'b1000, 8'hFF, 8'h01, lat);
    check("add_lat", lat, 8);
    check("add_result", result8, 8'h00);
    check("add_carry", carry8, 1);
    check("add_zero", zero8, 1);
    check("add_illegal", illegal8, 0);
    @(posedge clk); #1;
    check("done_one_cycle", done8, 0);
    check("result_hold", result8, 8'h00);

    run8(4'b1001, 8'h05, 8'h07, lat);
    check("sub57_result", result8, 8'hFE);
    check("sub57_carry", carry8, 0);
    run8(4'b1001, 8'h07, 8'h05, lat);
    check("sub75_result", result8, 8'h02);
    check("sub75_carry", carry8, 1);

    begin
      logic [3:0] ops [6] = '{4'b0010, 4'b0011, 4'b0110, 4'b0111, 4'b0001, 4'b0100};
      logic [7:0] exps [6] = '{8'hAA, 8'h55, 8'hAF, 8'h5F, 8'h5A, 8'hA5};
      for (int i = 0; i < 6; i++) begin
        run8(ops[i], 8'hA5, 8'h0F, lat);
        check($sformatf("logic_%b_result", ops[i]), result8, exps[i]);
        check($sformatf("logic_%b_carry", ops[i]), carry8, 0);
      end
    end

    // Ignored start while busy
    @(negedge clk);
    op8 = 4'b1000; a8 = 8'h11; b8 = 8'h22; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    op8 = 4'b1001; a8 = 8'hFF; b8 = 8'h01; start8 = 1'b1;
    check("busy_mid", busy8, 1);
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 3;
    begin
      int m;
      wait_done8(m);
      lat += m;
    end
    check("ignore_lat", lat, 8);
    check("ignore_result", result8, 8'h33);
    @(posedge clk); #1;
    check("ignore_idle", busy8, 0);

    // Back-to-back: start held high through the first done
    @(negedge clk);
    op8 = 4'b1000; a8 = 8'h01; b8 = 8'h02; start8 = 1'b1;
    @(posedge clk); #1;
    a8 = 8'h10; b8 = 8'h20;
    wait_done8(lat);
    start8 = 1'b0;
    check("b2b_lat1", lat, 8);
    check("b2b_result1", result8, 8'h03);
    check("b2b_busy", busy8, 1);
    wait_done8(lat);
    check("b2b_gap", lat, 8);
    check("b2b_result2", result8, 8'h30);

    // Reset mid-operation
    @(negedge clk);
    op8 = 4'b1000; a8 = 8'h40; b8 = 8'h01; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    #1 rst = 1'b1;
    #1;
    check("abort_busy", busy8, 0);
    check("abort_result", result8, 0);
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done8) done_seen++;
    end
    check("abort_no_done", done_seen, 0);

    run8(4'b1100, 8'h5A, 8'h3C, lat);
    check("rsvd_lat", lat, 8);
    check("rsvd_illegal", illegal8, 1);
    check("rsvd_zero", zero8, 1);
    check("rsvd_result", result8, 0);
    check("rsvd_carry", carry8, 0);
    run8(4'b1000, 8'h01, 8'h01, lat);
    check("illegal_clears", {illegal8, zero8, result8}, {1'b0, 1'b0, 8'h02});

    // WIDTH=16 ADD
    @(negedge clk);
    op16 = 4'b1000; a16 = 16'hFFFF; b16 = 16'h0001; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    lat = 0;
    while (lat < 60) begin
      @(posedge clk); #1;
      lat++;
      if (done16) break;
    end
    check("w16_lat", lat, 16);
    check("w16_result", result16, 16'h0000);
    check("w16_carry", carry16, 1);
    check("w16_zero", zero16, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
